// File: rtl/fighter_action_sequencer.sv
// Per-player action conditioner: tick-based stability filters, an attack FSM with
// active/cooldown windows, and movement arbitration for NUM_PLAYERS channels.
module fighter_action_sequencer #(
  parameter int NUM_PLAYERS    = 2,
  parameter int STABLE_TICKS   = 3,
  parameter int ATTACK_TICKS   = 8,
  parameter int COOLDOWN_TICKS = 4
) (
  input  logic                   clk_65mhz,
  input  logic                   rst_n,
  input  logic                   tick,
  input  logic [NUM_PLAYERS-1:0] raw_punch,
  input  logic [NUM_PLAYERS-1:0] raw_kick,
  input  logic [NUM_PLAYERS-1:0] raw_fwd,
  input  logic [NUM_PLAYERS-1:0] raw_back,
  output logic [NUM_PLAYERS-1:0] attack_start,
  output logic [NUM_PLAYERS-1:0] attacking,
  output logic [NUM_PLAYERS-1:0] attack_is_kick,
  output logic [NUM_PLAYERS-1:0] move_fwd,
  output logic [NUM_PLAYERS-1:0] move_back,
  output logic                   any_busy
);

  localparam int FW    = $clog2(STABLE_TICKS + 1);
  localparam int MAX_T = (ATTACK_TICKS > COOLDOWN_TICKS) ? ATTACK_TICKS : COOLDOWN_TICKS;
  localparam int CW    = $clog2(MAX_T + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ATTACK   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  logic [NUM_PLAYERS-1:0] busy_s;

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    // Filter slot order: 0 punch, 1 kick, 2 fwd, 3 back.
    logic [3:0]    raw_s;
    logic [3:0]    filt_r;
    logic [FW-1:0] fcnt_r [4];
    logic          prev_punch_r;
    logic          prev_kick_r;
    logic          punch_rise_s;
    logic          kick_rise_s;
    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic          start_r;
    logic          start_s;
    logic          kick_r;
    logic          kick_s;
    logic          attacking_s;

    assign raw_s        = {raw_back[p], raw_fwd[p], raw_kick[p], raw_punch[p]};
    assign punch_rise_s = filt_r[0] & ~prev_punch_r;
    assign kick_rise_s  = filt_r[1] & ~prev_kick_r;

    always_ff @(posedge clk_65mhz or negedge rst_n) begin
      if (!rst_n) begin
        filt_r <= 4'b0000;
        for (int f = 0; f < 4; f++) begin
          fcnt_r[f] <= {FW{1'b0}};
        end
      end else if (tick) begin
        for (int f = 0; f < 4; f++) begin
          if (raw_s[f] == filt_r[f]) begin
            fcnt_r[f] <= {FW{1'b0}};
          end else if (fcnt_r[f] == FW'(STABLE_TICKS - 1)) begin
            filt_r[f] <= raw_s[f];
            fcnt_r[f] <= {FW{1'b0}};
          end else begin
            fcnt_r[f] <= fcnt_r[f] + FW'(1);
          end
        end
      end
    end

    // Edges seen outside IDLE are dropped because the history register tracks every clock.
    always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      start_s = 1'b0;
      kick_s  = kick_r;
      case (state_r)
        IDLE: begin
          if (punch_rise_s || kick_rise_s) begin
            state_s = ATTACK;
            cnt_s   = {CW{1'b0}};
            start_s = 1'b1;
            kick_s  = ~punch_rise_s;
          end else begin
            state_s = IDLE;
          end
        end
        ATTACK: begin
          if (tick && (cnt_r == CW'(ATTACK_TICKS - 1))) begin
            state_s = COOLDOWN;
            cnt_s   = {CW{1'b0}};
          end else if (tick) begin
            cnt_s = cnt_r + CW'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
        COOLDOWN: begin
          if (tick && (cnt_r == CW'(COOLDOWN_TICKS - 1))) begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
          end else if (tick) begin
            cnt_s = cnt_r + CW'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = {CW{1'b0}};
        end
      endcase
    end

    always_ff @(posedge clk_65mhz or negedge rst_n) begin
      if (!rst_n) begin
        state_r      <= IDLE;
        cnt_r        <= {CW{1'b0}};
        start_r      <= 1'b0;
        kick_r       <= 1'b0;
        prev_punch_r <= 1'b0;
        prev_kick_r  <= 1'b0;
      end else begin
        state_r      <= state_s;
        cnt_r        <= cnt_s;
        start_r      <= start_s;
        kick_r       <= kick_s;
        prev_punch_r <= filt_r[0];
        prev_kick_r  <= filt_r[1];
      end
    end

    assign attacking_s       = (state_r == ATTACK);
    assign attack_start[p]   = start_r;
    assign attacking[p]      = attacking_s;
    assign attack_is_kick[p] = kick_r;
    assign busy_s[p]         = (state_r != IDLE);
    assign move_fwd[p]       = filt_r[2] & ~filt_r[3] & ~attacking_s;
    assign move_back[p]      = filt_r[3] & ~filt_r[2] & ~attacking_s;
  end

  assign any_busy = |busy_s;

endmodule

// File: tb/tb_fighter_action_sequencer.sv
// Directed bench for fighter_action_sequencer with four players and default timing.
module tb_fighter_action_sequencer;

  logic       clk_65mhz;
  logic       rst_n;
  logic       tick;
  logic [3:0] raw_punch;
  logic [3:0] raw_kick;
  logic [3:0] raw_fwd;
  logic [3:0] raw_back;
  logic [3:0] attack_start;
  logic [3:0] attacking;
  logic [3:0] attack_is_kick;
  logic [3:0] move_fwd;
  logic [3:0] move_back;
  logic       any_busy;

  int total = 0;
  int bad   = 0;

  fighter_action_sequencer #(
    .NUM_PLAYERS(4), .STABLE_TICKS(3), .ATTACK_TICKS(8), .COOLDOWN_TICKS(4)
  ) dut (
    .clk_65mhz(clk_65mhz), .rst_n(rst_n), .tick(tick),
    .raw_punch(raw_punch), .raw_kick(raw_kick), .raw_fwd(raw_fwd), .raw_back(raw_back),
    .attack_start(attack_start), .attacking(attacking), .attack_is_kick(attack_is_kick),
    .move_fwd(move_fwd), .move_back(move_back), .any_busy(any_busy)
  );

  initial begin
    clk_65mhz = 1'b0;
    forever #5 clk_65mhz = ~clk_65mhz;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock edge, optionally a tick edge; outputs are sampled 1 ns after it.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk_65mhz);
    #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1);
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0;
    raw_punch = 4'b0000; raw_kick = 4'b0000; raw_fwd = 4'b0000; raw_back = 4'b0000;
    cyc(1'b0); cyc(1'b0);
    check("rst_start", attack_start, 4'b0000);
    check("rst_attacking", attacking, 4'b0000);
    check("rst_kind", attack_is_kick, 4'b0000);
    check("rst_fwd", move_fwd, 4'b0000);
    check("rst_back", move_back, 4'b0000);
    check("rst_busy", {3'b000, any_busy}, 4'b0000);
    rst_n = 1'b1;
    cyc(1'b0); cyc(1'b0);
    check("release_no_pulse", attack_start, 4'b0000);

    // Glitch: 2 ticks high then low.
    raw_punch = 4'b0001; ticks(2);
    raw_punch = 4'b0000; ticks(1);
    cyc(1'b0); cyc(1'b0);
    check("glitch_busy", {3'b000, any_busy}, 4'b0000);
    check("glitch_start", attack_start, 4'b0000);

    // Punch accept, counter must have restarted from zero.
    raw_punch = 4'b0001;
    ticks(2);
    check("punch_t2_busy", {3'b000, any_busy}, 4'b0000);
    ticks(1);
    check("punch_t3_start", attack_start, 4'b0000);
    cyc(1'b0);
    check("punch_start", attack_start, 4'b0001);
    check("punch_attacking", attacking, 4'b0001);
    check("punch_kind", attack_is_kick, 4'b0000);
    cyc(1'b0);
    check("punch_pulse_end", attack_start, 4'b0000);
    ticks(7);
    check("punch_att7", attacking, 4'b0001);
    ticks(1);
    check("punch_att8", attacking, 4'b0000);
    check("punch_cool_busy", {3'b000, any_busy}, 4'b0001);
    ticks(3);
    check("punch_cool3", {3'b000, any_busy}, 4'b0001);
    ticks(1);
    check("punch_cool4", {3'b000, any_busy}, 4'b0000);
    ticks(5);
    check("held_no_retrigger", {3'b000, any_busy}, 4'b0000);
    raw_punch = 4'b0000; ticks(3);

    // Simultaneous punch+kick on player 1, then discarded edges.
    raw_punch = 4'b0010; raw_kick = 4'b0010;
    ticks(3); cyc(1'b0);
    check("sim_start", attack_start, 4'b0010);
    check("sim_kind", attack_is_kick, 4'b0000);
    raw_punch = 4'b0000; raw_kick = 4'b0000; ticks(3);
    raw_kick = 4'b0010; ticks(3); cyc(1'b0);
    check("kick_in_attack", attack_start, 4'b0000);
    raw_punch = 4'b0010; ticks(3); cyc(1'b0);
    check("punch_in_cooldown", attack_start, 4'b0000);
    check("cool_attacking", attacking, 4'b0000);
    check("cool_busy", {3'b000, any_busy}, 4'b0001);
    raw_punch = 4'b0000; raw_kick = 4'b0000;
    ticks(2);
    check("sim_cool_busy", {3'b000, any_busy}, 4'b0001);
    ticks(1);
    check("sim_idle", {3'b000, any_busy}, 4'b0000);
    check("sim_kind_hold", attack_is_kick, 4'b0000);

    // Kick-only attack on player 1; kind holds afterwards.
    raw_kick = 4'b0010; ticks(3); cyc(1'b0);
    check("kick_start", attack_start, 4'b0010);
    check("kick_kind", attack_is_kick, 4'b0010);
    raw_kick = 4'b0000; ticks(12);
    check("kick_idle", {3'b000, any_busy}, 4'b0000);
    check("kick_kind_hold", attack_is_kick, 4'b0010);

    // Movement arbitration on player 0.
    raw_fwd = 4'b0001; ticks(2);
    check("fwd_t2", move_fwd, 4'b0000);
    ticks(1);
    check("fwd_t3", move_fwd, 4'b0001);
    check("fwd_back0", move_back, 4'b0000);
    raw_back = 4'b0001; ticks(2);
    check("both_t2", move_fwd, 4'b0001);
    ticks(1);
    check("both_fwd", move_fwd, 4'b0000);
    check("both_back", move_back, 4'b0000);
    raw_fwd = 4'b0000; ticks(3);
    check("back_only", move_back, 4'b0001);
    check("back_only_fwd", move_fwd, 4'b0000);
    raw_back = 4'b0000; raw_fwd = 4'b0001; ticks(3);
    check("fwd_again", move_fwd, 4'b0001);
    raw_punch = 4'b0001; ticks(3);
    check("fwd_before_attack", move_fwd, 4'b0001);
    cyc(1'b0);
    check("fwd_attacking", attacking, 4'b0001);
    check("fwd_suppressed", move_fwd, 4'b0000);
    ticks(7);
    check("fwd_suppressed7", move_fwd, 4'b0000);
    ticks(1);
    check("fwd_in_cooldown", move_fwd, 4'b0001);
    ticks(4);
    raw_punch = 4'b0000; raw_fwd = 4'b0000; ticks(3);
    check("move_cleared", move_fwd, 4'b0000);

    // Staggered kicks on players 0 and 3.
    raw_kick = 4'b0001; ticks(3); cyc(1'b0);
    check("p0_start", attack_start, 4'b0001);
    raw_kick = 4'b1001; ticks(3); cyc(1'b0);
    check("p3_start", attack_start, 4'b1000);
    check("both_attacking", attacking, 4'b1001);
    ticks(5);
    check("p0_cooldown", attacking, 4'b1000);
    ticks(3);
    check("p3_cooldown", attacking, 4'b0000);
    check("both_busy", {3'b000, any_busy}, 4'b0001);
    ticks(1);
    check("p3_still_busy", {3'b000, any_busy}, 4'b0001);
    ticks(3);
    check("indep_idle", {3'b000, any_busy}, 4'b0000);
    check("indep_kind", attack_is_kick, 4'b1011);
    raw_kick = 4'b0000; ticks(3);

    // Reset mid-attack.
    raw_punch = 4'b0001; ticks(3); cyc(1'b0);
    check("pre_rst_attacking", attacking, 4'b0001);
    ticks(5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_attacking", attacking, 4'b0000);
    check("mid_rst_busy", {3'b000, any_busy}, 4'b0000);
    check("mid_rst_kind", attack_is_kick, 4'b0000);
    cyc(1'b0);
    #2 rst_n = 1'b1;
    ticks(2);
    check("post_rst_t2", {3'b000, any_busy}, 4'b0000);
    ticks(1);
    check("post_rst_t3", attack_start, 4'b0000);
    cyc(1'b0);
    check("post_rst_start", attack_start, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fighter_action_sequencer.md
# fighter_action_sequencer

Parametrised per-player action conditioner between the camera pose classifier and the game logic. It generalises the fixed p1/p2 punch/kick/move strobes to NUM_PLAYERS channels. Each channel gets:
- a tick-based stability filter on its raw inputs,
- an attack state machine with active and cooldown windows,
- movement arbitration.

The game engine consumes clean one-cycle attack starts, attack-in-progress levels and mutually exclusive movement levels.

## Interface
- NUM_PLAYERS, 2, number of independent player channels (>=1)
- STABLE_TICKS, 3, consecutive ticks a raw input must differ from its filtered value before the filtered value changes (>=1)
- ATTACK_TICKS, 8, ticks an attack stays active (>=1)
- COOLDOWN_TICKS, 4, ticks after an attack during which no new attack is accepted (>=1)

Ports:
- clk_65mhz  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- tick  input  1  timebase strobe (one cycle, e.g. per video frame); all filters and counters advance only on tick=1 cycles
- raw_punch  input  NUM_PLAYERS  classifier punch request, bit i = player i
- raw_kick  input  NUM_PLAYERS  classifier kick request
- raw_fwd  input  NUM_PLAYERS  classifier move-forwards request
- raw_back  input  NUM_PLAYERS  classifier move-backwards request
- attack_start  output  NUM_PLAYERS  one-cycle pulse when an attack is accepted
- attacking  output  NUM_PLAYERS  high during the ATTACK state
- attack_is_kick  output  NUM_PLAYERS  kind of the current or last attack: 1 = kick, 0 = punch
- move_fwd  output  NUM_PLAYERS  filtered forward movement, arbitrated
- move_back  output  NUM_PLAYERS  filtered backward movement, arbitrated
- any_busy  output  1  OR over all players of (state != IDLE)

## Operation
- **Channel independence.** Each channel is fully independent. There is no cross-player interaction except any_busy.
- **Stability filter.**
  - There are 4 filters per channel: punch, kick, fwd, back. Each has a filtered bit and a counter of width $clog2(STABLE_TICKS+1).
  - The filter acts only on tick cycles:
    - raw == filtered: counter <= 0.
    - raw != filtered and counter == STABLE_TICKS-1: filtered <= raw, counter <= 0.
    - Otherwise: counter increments.
  - Raw values between ticks are ignored.
- **Edge detection.** A registered copy of filtered punch and kick provides rising-edge detection: filtered=1 and previous=0.
- **Attack FSM states.** IDLE, ATTACK, COOLDOWN. There is one shared tick counter of width $clog2(max(ATTACK_TICKS,COOLDOWN_TICKS)+1).
- **IDLE.**
  - A punch or kick rising edge moves the FSM to ATTACK, clears the counter and latches attack_is_kick.
  - Simultaneous punch and kick edges: punch wins, so attack_is_kick=0.
- **ATTACK.** On each tick the counter increments. On the tick where counter == ATTACK_TICKS-1, the FSM moves to COOLDOWN and the counter clears.
- **COOLDOWN.** Same counting rule against COOLDOWN_TICKS-1, then the FSM returns to IDLE.
- **Edges outside IDLE.** Rising edges during ATTACK or COOLDOWN are discarded, not queued. A button still held when the FSM returns to IDLE does not retrigger; a new filtered rising edge is required.
- **Movement arbitration.**
  - move_fwd = filt_fwd & ~filt_back & ~attacking. move_back is symmetric.
  - Both filtered bits high gives 0/0.
  - Movement is suppressed during ATTACK but allowed during COOLDOWN.
- **attack_is_kick hold.** attack_is_kick holds its value until the next accepted attack.

## Timing
- **Reset values.** While rst_n=0:
  - all filtered bits, counters and edge registers = 0;
  - FSM = IDLE;
  - every output = 0.
- **Reset release.** No pulse is generated merely by releasing reset.
- **Filter latency.** filtered changes in the cycle after the STABLE_TICKS-th consecutive differing tick.
- **Edge register.** The edge register updates every clock.
- **attack_start.**
  - Registered; high exactly one clock, in the cycle after filtered punch/kick rises.
  - attacking rises in the same cycle as attack_start.
- **ATTACK duration.** attacking stays high for exactly ATTACK_TICKS ticks. It falls in the cycle after the ATTACK_TICKS-th tick seen while attacking=1. A tick coincident with the acceptance cycle is not counted.
- **IDLE re-entry.** any_busy falls in the cycle after the COOLDOWN_TICKS-th cooldown tick. The earliest next attack_start is 2 clocks after that, given a fresh edge.
- **Move outputs.** move_fwd and move_back are combinational from registered state: zero added latency after the filtered values and attacking.
- **Reset mid-attack.** Asserting rst_n mid-attack clears everything immediately (asynchronously).
- **tick held high.** If tick is held high continuously, the block behaves as if counting clocks.

## Test plan
- **Glitch rejection.** Defaults. Raise raw_punch[0] for 2 ticks, then lower it -> no attack_start, attacking=0, all counters back to 0.
- **Punch accept and timing.** raw_punch[0] high for 3 ticks -> attack_start[0] single pulse in the cycle after the 3rd tick, attack_is_kick[0]=0. attacking[0] high for exactly 8 ticks, any_busy high for 12 ticks total.
- **Simultaneous and discarded edges.**
  - raw_punch[1] and raw_kick[1] rise on the same tick -> one attack_start[1], attack_is_kick[1]=0.
  - A kick re-press during ATTACK or COOLDOWN -> no second pulse.
  - Held punch after IDLE re-entry -> no retrigger.
- **Movement arbitration.**
  - raw_fwd[0]=1, raw_back[0]=0 -> move_fwd[0]=1 after 3 ticks.
  - Then raw_back[0]=1 -> both outputs 0 after 3 more ticks.
  - Start an attack -> move outputs 0 while attacking=1; they return during COOLDOWN.
- **Channel independence.** NUM_PLAYERS=4, staggered kicks on players 0 and 3 -> independent pulses and windows. any_busy = OR of the two busy windows, players 1 and 2 stay 0.
- **Reset mid-attack.** Pull rst_n low 5 ticks into an attack -> all outputs 0 immediately. After release with raw_punch still high -> a new attack_start only after STABLE_TICKS ticks.
